wb_queue: RTL and testbench

Write-side companion of the 8x8 pipeline register file: buffers writeback results from the EX/MEM side in a small in-order FIFO and drains one entry per cycle into the register-file write port (we/wa/wd). While results are pending (queued or in the write register), it provides newest-value forwarding lookups for two read addresses, so decode-stage reads stay coherent with the combinational register-file read ports.

---
 rtl/wb_queue.sv | 140 ++++++++++++++
 tb/tb_wb_queue.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback queue in front of the 8x8 register file: in-order FIFO of (addr, data)
// results drained one per cycle into a registered write port, with newest-value forwarding.
module wb_queue #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2:0]    in_wa,
    input  logic [7:0]    in_wd,
    input  logic          hold,
    output logic          we,
    output logic [2:0]    wa,
    output logic [7:0]    wd,
    input  logic [2:0]    ra1,
    input  logic [2:0]    ra2,
    output logic          fwd1_hit,
    output logic          fwd2_hit,
    output logic [7:0]    fwd1_data,
    output logic [7:0]    fwd2_data,
    output logic [CW-1:0] count,
    output logic          empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]    q_wa_q [DEPTH];
    logic [2:0]    q_wa_d [DEPTH];
    logic [7:0]    q_wd_q [DEPTH];
    logic [7:0]    q_wd_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          we_q, we_d;
    logic [2:0]    wa_q, wa_d;
    logic [7:0]    wd_q, wd_d;

    logic          push;
    logic          pop;

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
    // in_ready looks only at the stored count, so a full queue stalls even while draining.
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready && (in_wa != 3'd0);
    assign pop      = (count_q != '0) && !hold;

    always_comb begin
        q_wa_d  = q_wa_q;
        q_wd_d  = q_wd_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        we_d    = pop;
        wa_d    = wa_q;
        wd_d    = wd_q;
        if (push) begin
            q_wa_d[tail_q] = in_wa;
            q_wd_d[tail_q] = in_wd;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            wa_d   = q_wa_q[head_q];
            wd_d   = q_wd_q[head_q];
            head_d = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_wa_q[i] <= 3'd0;
                q_wd_q[i] <= 8'd0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wa_q    <= 3'd0;
            wd_q    <= 8'd0;
        end else begin
            q_wa_q  <= q_wa_d;
            q_wd_q  <= q_wd_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

    logic [2:0]    look_ra   [2];
    logic          look_hit  [2];
    logic [7:0]    look_data [2];
    logic [PW-1:0] idx;

    assign look_ra[0] = ra1;
    assign look_ra[1] = ra2;

    // Scan oldest to newest so the newest matching entry overrides; write register is lowest.
    always_comb begin
        idx = '0;
        for (int p = 0; p < 2; p++) begin
            look_hit[p]  = 1'b0;
            look_data[p] = 8'd0;
            if (look_ra[p] != 3'd0) begin
                if (we_q && (wa_q == look_ra[p])) begin
                    look_hit[p]  = 1'b1;
                    look_data[p] = wd_q;
                end
                for (int i = 0; i < DEPTH; i++) begin
                    idx = head_q + PW'(i);
                    if ((CW'(i) < count_q) && (q_wa_q[idx] == look_ra[p])) begin
                        look_hit[p]  = 1'b1;
                        look_data[p] = q_wd_q[idx];
                    end
                end
            end
        end
    end

    assign fwd1_hit  = look_hit[0];
    assign fwd1_data = look_data[0];
    assign fwd2_hit  = look_hit[1];
    assign fwd2_data = look_data[1];

    assign we    = we_q;
    assign wa    = wa_q;
    assign wd    = wd_q;
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: per-cycle vector table, reset checks, a reset-mid-drain sequence
// and an end-of-run comparison of every register-file write against the expected order.
module tb_wb_queue;

    logic       clk = 1'b0;
    logic       rstn;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] in_wa;
    logic [7:0] in_wd;
    logic       hold;
    logic       we;
    logic [2:0] wa;
    logic [7:0] wd;
    logic [2:0] ra1, ra2;
    logic       fwd1_hit, fwd2_hit;
    logic [7:0] fwd1_data, fwd2_data;
    logic [2:0] count;
    logic       empty;

    wb_queue #(.DEPTH(4), .CW(3)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_wa(in_wa), .in_wd(in_wd), .hold(hold), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit),
        .fwd1_data(fwd1_data), .fwd2_data(fwd2_data), .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    // Register file attached to the write port, plus a log of every write it takes.
    logic [7:0]  rf [8];
    logic [10:0] got_q [$];
    logic [10:0] exp_q [$];

    always @(posedge clk) begin
        if (we) begin
            rf[wa] <= wd;
            got_q.push_back({wa, wd});
        end
    end

    typedef struct {
        logic       v;
        logic [2:0] wa;
        logic [7:0] wd;
        logic       hold;
        logic [2:0] ra1;
        logic [2:0] ra2;
        logic       rdy;
        logic       we;
        logic [2:0] owa;
        logic [7:0] owd;
        logic [2:0] cnt;
        logic       h1;
        logic [7:0] d1;
        logic       h2;
        logic [7:0] d2;
    } vec_t;

    vec_t vecs [$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cur_row = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got %0h expected %0h", name, cur_row, act, exp);
    endtask

    task automatic add_row(input logic v, input logic [2:0] iwa, input logic [7:0] iwd,
                           input logic h, input logic [2:0] r1, input logic [2:0] r2,
                           input logic rdy, input logic ewe, input logic [2:0] owa,
                           input logic [7:0] owd, input logic [2:0] cnt,
                           input logic h1, input logic [7:0] d1,
                           input logic h2, input logic [7:0] d2);
        vec_t r;
        r.v = v; r.wa = iwa; r.wd = iwd; r.hold = h; r.ra1 = r1; r.ra2 = r2;
        r.rdy = rdy; r.we = ewe; r.owa = owa; r.owd = owd; r.cnt = cnt;
        r.h1 = h1; r.d1 = d1; r.h2 = h2; r.d2 = d2;
        vecs.push_back(r);
    endtask

    task automatic check_idle_reset();
        check("rst_in_ready", in_ready, 1);
        check("rst_we", we, 0);
        check("rst_wa", wa, 0);
        check("rst_wd", wd, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_hit1", fwd1_hit, 0);
        check("rst_data1", fwd1_data, 0);
        check("rst_hit2", fwd2_hit, 0);
        check("rst_data2", fwd2_data, 0);
    endtask

    initial begin
        // Rows: inputs for one cycle, and the outputs expected during that cycle.
        //       v wa wd     hd r1 r2  rdy we owa owd    cnt h1 d1     h2 d2
        add_row(1, 3, 8'h5A, 0, 3, 0,  1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00); // 0
        add_row(0, 0, 8'h00, 0, 3, 0,  1, 0, 0, 8'h00, 1, 1, 8'h5A, 0, 8'h00);
        add_row(0, 0, 8'h00, 0, 3, 0,  1, 1, 3, 8'h5A, 0, 1, 8'h5A, 0, 8'h00);
        add_row(0, 0, 8'h00, 0, 3, 0,  1, 0, 3, 8'h5A, 0, 0, 8'h00, 0, 8'h00);
        add_row(1, 1, 8'h11, 1, 1, 4,  1, 0, 3, 8'h5A, 0, 0, 8'h00, 0, 8'h00); // 4
        add_row(1, 2, 8'h22, 1, 1, 4,  1, 0, 3, 8'h5A, 1, 1, 8'h11, 0, 8'h00);
        add_row(1, 3, 8'h33, 1, 1, 4,  1, 0, 3, 8'h5A, 2, 1, 8'h11, 0, 8'h00);
        add_row(1, 4, 8'h44, 1, 1, 4,  1, 0, 3, 8'h5A, 3, 1, 8'h11, 0, 8'h00);
        add_row(1, 5, 8'h55, 1, 1, 4,  0, 0, 3, 8'h5A, 4, 1, 8'h11, 1, 8'h44);
        add_row(0, 0, 8'h00, 0, 1, 4,  0, 0, 3, 8'h5A, 4, 1, 8'h11, 1, 8'h44);
        add_row(0, 0, 8'h00, 0, 1, 4,  1, 1, 1, 8'h11, 3, 1, 8'h11, 1, 8'h44); // 10
        add_row(0, 0, 8'h00, 0, 1, 4,  1, 1, 2, 8'h22, 2, 0, 8'h00, 1, 8'h44);
        add_row(0, 0, 8'h00, 0, 1, 4,  1, 1, 3, 8'h33, 1, 0, 8'h00, 1, 8'h44);
        add_row(0, 0, 8'h00, 0, 1, 4,  1, 1, 4, 8'h44, 0, 0, 8'h00, 1, 8'h44);
        add_row(0, 0, 8'h00, 0, 1, 4,  1, 0, 4, 8'h44, 0, 0, 8'h00, 0, 8'h00);
        add_row(1, 5, 8'h01, 1, 0, 5,  1, 0, 4, 8'h44, 0, 0, 8'h00, 0, 8'h00); // 15
        add_row(1, 5, 8'h02, 1, 0, 5,  1, 0, 4, 8'h44, 1, 0, 8'h00, 1, 8'h01);
        add_row(1, 5, 8'h03, 1, 0, 5,  1, 0, 4, 8'h44, 2, 0, 8'h00, 1, 8'h02);
        add_row(0, 0, 8'h00, 0, 0, 5,  1, 0, 4, 8'h44, 3, 0, 8'h00, 1, 8'h03);
        add_row(0, 0, 8'h00, 0, 0, 5,  1, 1, 5, 8'h01, 2, 0, 8'h00, 1, 8'h03);
        add_row(0, 0, 8'h00, 0, 0, 5,  1, 1, 5, 8'h02, 1, 0, 8'h00, 1, 8'h03); // 20
        add_row(0, 0, 8'h00, 0, 0, 5,  1, 1, 5, 8'h03, 0, 0, 8'h00, 1, 8'h03);
        add_row(0, 0, 8'h00, 0, 0, 5,  1, 0, 5, 8'h03, 0, 0, 8'h00, 0, 8'h00);
        add_row(1, 0, 8'hFF, 0, 0, 0,  1, 0, 5, 8'h03, 0, 0, 8'h00, 0, 8'h00);
        add_row(0, 0, 8'h00, 0, 0, 0,  1, 0, 5, 8'h03, 0, 0, 8'h00, 0, 8'h00);
        add_row(0, 0, 8'h00, 0, 0, 0,  1, 0, 5, 8'h03, 0, 0, 8'h00, 0, 8'h00); // 25
        add_row(1, 1, 8'hA1, 1, 6, 7,  1, 0, 5, 8'h03, 0, 0, 8'h00, 0, 8'h00);
        add_row(1, 2, 8'hA2, 1, 6, 7,  1, 0, 5, 8'h03, 1, 0, 8'h00, 0, 8'h00);
        add_row(1, 3, 8'hA3, 1, 6, 7,  1, 0, 5, 8'h03, 2, 0, 8'h00, 0, 8'h00);
        add_row(1, 4, 8'hA4, 1, 6, 7,  1, 0, 5, 8'h03, 3, 0, 8'h00, 0, 8'h00);
        add_row(1, 6, 8'hB6, 0, 6, 7,  0, 0, 5, 8'h03, 4, 0, 8'h00, 0, 8'h00); // 30
        add_row(1, 6, 8'hB6, 0, 6, 7,  1, 1, 1, 8'hA1, 3, 0, 8'h00, 0, 8'h00);
        add_row(1, 7, 8'hB7, 0, 6, 7,  1, 1, 2, 8'hA2, 3, 1, 8'hB6, 0, 8'h00);
        add_row(0, 0, 8'h00, 0, 6, 7,  1, 1, 3, 8'hA3, 3, 1, 8'hB6, 1, 8'hB7);
        add_row(0, 0, 8'h00, 0, 6, 7,  1, 1, 4, 8'hA4, 2, 1, 8'hB6, 1, 8'hB7);
        add_row(0, 0, 8'h00, 0, 6, 7,  1, 1, 6, 8'hB6, 1, 1, 8'hB6, 1, 8'hB7); // 35
        add_row(0, 0, 8'h00, 0, 6, 7,  1, 1, 7, 8'hB7, 0, 0, 8'h00, 1, 8'hB7);
        add_row(0, 0, 8'h00, 0, 6, 7,  1, 0, 7, 8'hB7, 0, 0, 8'h00, 0, 8'h00);

        exp_q = '{{3'd3, 8'h5A}, {3'd1, 8'h11}, {3'd2, 8'h22}, {3'd3, 8'h33},
                  {3'd4, 8'h44}, {3'd5, 8'h01}, {3'd5, 8'h02}, {3'd5, 8'h03},
                  {3'd1, 8'hA1}, {3'd2, 8'hA2}, {3'd3, 8'hA3}, {3'd4, 8'hA4},
                  {3'd6, 8'hB6}, {3'd7, 8'hB7}};

        rstn = 1'b0; in_valid = 1'b0; in_wa = 3'd0; in_wd = 8'd0; hold = 1'b0;
        ra1 = 3'd3; ra2 = 3'd5;
        #12;
        check_idle_reset();
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cur_row = i;
            in_valid = vecs[i].v; in_wa = vecs[i].wa; in_wd = vecs[i].wd;
            hold = vecs[i].hold; ra1 = vecs[i].ra1; ra2 = vecs[i].ra2;
            #1;
            check("in_ready", in_ready, vecs[i].rdy);
            check("we", we, vecs[i].we);
            check("wa", wa, vecs[i].owa);
            check("wd", wd, vecs[i].owd);
            check("count", count, vecs[i].cnt);
            check("empty", empty, (vecs[i].cnt == 3'd0));
            check("fwd1_hit", fwd1_hit, vecs[i].h1);
            check("fwd1_data", fwd1_data, vecs[i].d1);
            check("fwd2_hit", fwd2_hit, vecs[i].h2);
            check("fwd2_data", fwd2_data, vecs[i].d2);
            if (i == 3) check("rf3", rf[3], 8'h5A);
            if (i == 22) check("rf5", rf[5], 8'h03);
            @(negedge clk);
        end

        // Reset while a write is loaded and three entries remain queued.
        cur_row = 100;
        hold = 1'b1; in_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_wa = 3'(k); in_wd = 8'hC0 + 8'(k);
            @(negedge clk);
        end
        in_valid = 1'b0; hold = 1'b0; ra1 = 3'd1; ra2 = 3'd2;
        #1;
        check("pre_count", count, 4);
        @(posedge clk);
        #2;
        check("pre_we", we, 1);
        check("pre_count3", count, 3);
        check("pre_hit1", fwd1_hit, 1);
        rstn = 1'b0;
        #1;
        check_idle_reset();
        @(negedge clk);
        rstn = 1'b1;
        repeat (6) @(negedge clk);
        cur_row = 101;
        check("post_we", we, 0);
        check("post_count", count, 0);
        check("post_rf1", rf[1], 8'hA1);

        cur_row = 200;
        check("write_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size()) check("write_order", got_q[k], exp_q[k]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
